// File: rtl/definitions_pkg.sv
// Shared constants, types and helpers for the Canny line-buffer window store.
package definitions_pkg;

    localparam int unsigned IMAGE_WIDTH = 512;
    localparam int unsigned NUM_LB      = 4;
    localparam int unsigned TAP_W       = 24;

    typedef enum logic {IDLE, RD} lbc_state_t;

    typedef logic [1:0]       lb_sel_t;
    typedef logic [TAP_W-1:0] lb_tap_t;

    typedef struct packed {
        lb_tap_t top;
        lb_tap_t mid;
        lb_tap_t bot;
    } lb_window_t;

    // Buffers sel, sel+1, sel+2 (mod 4) form the active 3-line window.
    function automatic logic [NUM_LB-1:0] rd_mask(input lb_sel_t sel);
        logic [2*NUM_LB-1:0] rot;
        rot = {2{4'b0111}} << sel;
        return rot[2*NUM_LB-1:NUM_LB];
    endfunction

    function automatic lb_tap_t tap_of(input logic [NUM_LB*TAP_W-1:0] taps, input lb_sel_t sel);
        return taps[TAP_W*32'(sel) +: TAP_W];
    endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Rotating 4-buffer line store controller: steers pixel writes round-robin per
// line and drains three full lines in lockstep as 3x3 windows.
module line_buffer_ctrl #(
    parameter int unsigned IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_valid,
    output logic [7:0]  o_lb_wr_data,
    output logic [3:0]  o_lb_wr_valid,
    output logic [3:0]  o_lb_rd_en,
    input  logic [95:0] i_lb_data,
    output logic [71:0] o_window,
    output logic        o_window_valid,
    output logic        o_intr,
    output logic        o_overflow
);
    import definitions_pkg::*;

    localparam int unsigned PIX_W  = $clog2(IMAGE_WIDTH);
    localparam int unsigned FILL_W = $clog2(4 * IMAGE_WIDTH) + 1;
    localparam int unsigned FULL   = 4 * IMAGE_WIDTH;
    localparam int unsigned THRESH = 3 * IMAGE_WIDTH;

    lbc_state_t        state_q, state_d;
    lb_sel_t           wr_sel_q, wr_sel_d;
    lb_sel_t           rd_sel_q, rd_sel_d;
    logic [PIX_W-1:0]  wr_pix_cnt_q, wr_pix_cnt_d;
    logic [PIX_W-1:0]  rd_pix_cnt_q, rd_pix_cnt_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    lb_window_t        window_q, window_d;
    logic              window_valid_q, window_valid_d;
    logic              intr_q, intr_d;
    logic              overflow_q, overflow_d;

    logic full_c;
    logic accept_c;
    logic rd_active_c;

    assign full_c      = (fill_cnt_q == FILL_W'(FULL));
    assign accept_c    = i_pixel_valid & ~full_c;
    assign rd_active_c = (state_q == RD);

    assign o_lb_wr_data   = i_pixel_data;
    assign o_lb_wr_valid  = accept_c ? 4'(4'b0001 << wr_sel_q) : 4'b0000;
    assign o_lb_rd_en     = rd_active_c ? rd_mask(rd_sel_q) : 4'b0000;
    assign o_window       = window_q;
    assign o_window_valid = window_valid_q;
    assign o_intr         = intr_q;
    assign o_overflow     = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_sel_q       <= '0;
            rd_sel_q       <= '0;
            wr_pix_cnt_q   <= '0;
            rd_pix_cnt_q   <= '0;
            fill_cnt_q     <= '0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            intr_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_sel_q       <= wr_sel_d;
            rd_sel_q       <= rd_sel_d;
            wr_pix_cnt_q   <= wr_pix_cnt_d;
            rd_pix_cnt_q   <= rd_pix_cnt_d;
            fill_cnt_q     <= fill_cnt_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            intr_q         <= intr_d;
            overflow_q     <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_sel_d       = wr_sel_q;
        rd_sel_d       = rd_sel_q;
        wr_pix_cnt_d   = wr_pix_cnt_q;
        rd_pix_cnt_d   = rd_pix_cnt_q;
        fill_cnt_d     = fill_cnt_q;
        window_d       = window_q;
        window_valid_d = 1'b0;
        intr_d         = 1'b0;
        overflow_d     = overflow_q | (i_pixel_valid & full_c);

        // Write side: a line boundary moves the strobe to the next buffer.
        if (accept_c) begin
            wr_pix_cnt_d = wr_pix_cnt_q + PIX_W'(1);
            if (wr_pix_cnt_q == PIX_W'(IMAGE_WIDTH - 1)) begin
                wr_sel_d = wr_sel_q + 2'd1;
            end
        end

        unique case ({accept_c, rd_active_c})
            2'b10:   fill_cnt_d = fill_cnt_q + FILL_W'(1);
            2'b01:   fill_cnt_d = fill_cnt_q - FILL_W'(1);
            default: fill_cnt_d = fill_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (fill_cnt_q >= FILL_W'(THRESH)) begin
                    state_d = RD;
                end
            end
            RD: begin
                window_d.top   = tap_of(i_lb_data, rd_sel_q);
                window_d.mid   = tap_of(i_lb_data, rd_sel_q + 2'd1);
                window_d.bot   = tap_of(i_lb_data, rd_sel_q + 2'd2);
                window_valid_d = 1'b1;
                rd_pix_cnt_d   = rd_pix_cnt_q + PIX_W'(1);
                // Oldest line fully consumed: release it to the source.
                if (rd_pix_cnt_q == PIX_W'(IMAGE_WIDTH - 1)) begin
                    rd_sel_d = rd_sel_q + 2'd1;
                    intr_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with behavioural line buffers and a
// line-level reference model.
module tb_line_buffer_ctrl;

    localparam int W    = 8;
    localparam int FULL = 4 * W;

    logic        clk;
    logic        rst;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_valid;
    logic [7:0]  o_lb_wr_data;
    logic [3:0]  o_lb_wr_valid;
    logic [3:0]  o_lb_rd_en;
    logic [95:0] lb_data;
    logic [71:0] o_window;
    logic        o_window_valid;
    logic        o_intr;
    logic        o_overflow;

    line_buffer_ctrl #(.IMAGE_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pixel_data   (i_pixel_data),
        .i_pixel_valid  (i_pixel_valid),
        .o_lb_wr_data   (o_lb_wr_data),
        .o_lb_wr_valid  (o_lb_wr_valid),
        .o_lb_rd_en     (o_lb_rd_en),
        .i_lb_data      (lb_data),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_intr         (o_intr),
        .o_overflow     (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural line buffers: tap = {p[rp], p[rp+1], p[rp+2]}, oldest column in the MSB.
    logic [7:0] mem [4][W];
    int wp [4];
    int rp [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < W; c++) mem[b][c] <= 8'h00;
                wp[b] <= 0;
                rp[b] <= 0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (o_lb_wr_valid[b]) begin
                    mem[b][wp[b]] <= o_lb_wr_data;
                    wp[b] <= (wp[b] + 1) % W;
                end
                if (o_lb_rd_en[b]) rp[b] <= (rp[b] + 1) % W;
            end
        end
    end

    always_comb begin
        lb_data = '0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 3; k++)
                lb_data[24*b + 16 - 8*k +: 8] = mem[b][(rp[b] + k) % W];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: line-level bookkeeping of stored pixels and the read pass.
    logic [7:0]  model_buf [4][W];
    int          m_fill, m_col, m_rs, m_ws, m_wc;
    bit          m_reading, m_ovf, exp_intr, exp_wv;
    logic [71:0] exp_win;

    logic [3:0]  last_wr_valid, last_rd_en;
    logic        last_wv, last_intr, last_ovf;
    logic [71:0] last_win;

    function automatic logic [3:0] exp_mask(input int s);
        logic [3:0] m;
        m = 4'b0000;
        for (int r = 0; r < 3; r++) m[(s + r) % 4] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        m_fill = 0; m_col = 0; m_rs = 0; m_ws = 0; m_wc = 0;
        m_reading = 0; m_ovf = 0; exp_intr = 0; exp_wv = 0; exp_win = '0;
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < W; c++) model_buf[b][c] = 8'h00;
    endtask

    // One clock cycle: drive, check against the model, advance both at the edge.
    task automatic step(input logic v, input logic [7:0] d);
        bit          acc, was_reading;
        int          old_fill;
        logic [3:0]  ewv, erd;
        logic [71:0] ew;
        i_pixel_valid = v;
        i_pixel_data  = d;
        #1;
        acc = v && (m_fill != FULL);
        ewv = acc ? 4'(1 << m_ws) : 4'b0000;
        erd = m_reading ? exp_mask(m_rs) : 4'b0000;
        chk("wr_data",  72'(o_lb_wr_data),   72'(d));
        chk("wr_valid", 72'(o_lb_wr_valid),  72'(ewv));
        chk("rd_en",    72'(o_lb_rd_en),     72'(erd));
        chk("win_vld",  72'(o_window_valid), 72'(exp_wv));
        chk("window",   o_window,            exp_win);
        chk("intr",     72'(o_intr),         72'(exp_intr));
        chk("overflow", 72'(o_overflow),     72'(m_ovf));
        last_wr_valid = o_lb_wr_valid;
        last_rd_en    = o_lb_rd_en;
        last_wv       = o_window_valid;
        last_win      = o_window;
        last_intr     = o_intr;
        last_ovf      = o_overflow;
        ew = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                ew[71 - 24*r - 8*k -: 8] = model_buf[(m_rs + r) % 4][(m_col + k) % W];
        @(posedge clk);
        was_reading = m_reading;
        old_fill    = m_fill;
        exp_wv      = was_reading;
        if (was_reading) exp_win = ew;
        exp_intr = was_reading && (m_col == W - 1);
        if (v && old_fill == FULL) m_ovf = 1;
        m_fill = old_fill + (acc ? 1 : 0) - (was_reading ? 1 : 0);
        if (acc) begin
            model_buf[m_ws][m_wc] = d;
            m_wc = (m_wc + 1) % W;
            if (m_wc == 0) m_ws = (m_ws + 1) % 4;
        end
        if (was_reading) begin
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_reading = 0;
                m_rs = (m_rs + 1) % 4;
            end
        end else if (old_fill >= 3 * W) begin
            m_reading = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        i_pixel_valid = 1'b0;
        i_pixel_data  = 8'h00;
        rst = 1'b1;
        #1;
        chk("rst_wr_valid", 72'(o_lb_wr_valid),  72'(0));
        chk("rst_wr_data",  72'(o_lb_wr_data),   72'(0));
        chk("rst_rd_en",    72'(o_lb_rd_en),     72'(0));
        chk("rst_window",   o_window,            72'(0));
        chk("rst_win_vld",  72'(o_window_valid), 72'(0));
        chk("rst_intr",     72'(o_intr),         72'(0));
        chk("rst_overflow", 72'(o_overflow),     72'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic observe(input int n, output int n_rd, output logic [3:0] fm,
                           output int n_wv, output logic [71:0] fw, output int n_intr);
        n_rd = 0; n_wv = 0; n_intr = 0; fm = 4'b0000; fw = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h00);
            if (last_rd_en != 4'b0000) begin
                if (n_rd == 0) fm = last_rd_en;
                n_rd++;
            end
            if (last_wv) begin
                if (n_wv == 0) fw = last_win;
                n_wv++;
            end
            if (last_intr) n_intr++;
        end
    endtask

    task automatic fill_scenario(input string pfx);
        int n_rd, n_wv, n_intr;
        logic [3:0] fm;
        logic [71:0] fw;
        for (int i = 0; i < 3 * W; i++) begin
            step(1'b1, 8'(i));
            chk({pfx, "_wr_strobe"}, 72'(last_wr_valid), 72'(4'(1 << (i / W))));
        end
        observe(14, n_rd, fm, n_wv, fw, n_intr);
        chk({pfx, "_rd_cycles"}, 72'(n_rd), 72'(W));
        chk({pfx, "_rd_mask"},   72'(fm),   72'(4'b0111));
        chk({pfx, "_wv_cycles"}, 72'(n_wv), 72'(W));
        chk({pfx, "_first_win"}, fw,        72'h00_01_02_08_09_0A_10_11_12);
        chk({pfx, "_intr_cnt"},  72'(n_intr), 72'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd, n_wv, n_intr, k;
        logic [3:0] fm;
        logic [71:0] fw;
        logic [3:0] rot_masks [4];
        rot_masks[0] = 4'b1110;
        rot_masks[1] = 4'b1101;
        rot_masks[2] = 4'b1011;
        rot_masks[3] = 4'b0111;

        rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_rd_en",    72'(o_lb_rd_en),     72'(0));
        chk("init_window",   o_window,            72'(0));
        chk("init_overflow", 72'(o_overflow),     72'(0));
        rst = 1'b0;

        // Reset in the middle of a line, then first pixel lands in buffer 0.
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        do_reset();
        step(1'b1, 8'h5A);
        chk("post_rst_strobe", 72'(last_wr_valid), 72'(4'b0001));
        do_reset();

        fill_scenario("fill");

        // Rotation over four more lines.
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < W; i++) step(1'b1, 8'($urandom));
            observe(12, n_rd, fm, n_wv, fw, n_intr);
            chk("rot_mask",   72'(fm),     72'(rot_masks[ln]));
            chk("rot_cycles", 72'(n_rd),   72'(W));
            chk("rot_intr",   72'(n_intr), 72'(1));
        end

        // Concurrent write of line 3 during the first read pass.
        do_reset();
        for (int i = 0; i < 3 * W; i++) step(1'b1, 8'($urandom));
        step(1'b0, 8'h00);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 8'($urandom));
            chk("conc_wr_strobe", 72'(last_wr_valid), 72'(4'b1000));
            chk("conc_rd_mask",   72'(last_rd_en),    72'(4'b0111));
        end
        observe(12, n_rd, fm, n_wv, fw, n_intr);
        chk("conc_second_mask",   72'(fm),   72'(4'b1110));
        chk("conc_second_cycles", 72'(n_rd), 72'(W));

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 8'($urandom));

        // Overflow: keep writing until all four lines are occupied.
        do_reset();
        k = 0;
        while (m_fill != FULL && k < 400) begin
            step(1'b1, 8'($urandom));
            k++;
        end
        checks++;
        assert (k < 400) else begin
            failures++;
            $error("FAIL ovf_reach observed=%0d expected=<400", k);
        end
        step(1'b1, 8'hAA);
        chk("ovf_drop",   72'(last_wr_valid), 72'(0));
        chk("ovf_before", 72'(last_ovf),      72'(0));
        step(1'b0, 8'h00);
        chk("ovf_set",    72'(last_ovf),      72'(1));
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
        chk("ovf_sticky", 72'(last_ovf),      72'(1));

        // Reset on read cycle 4 aborts the pass with no interrupt.
        do_reset();
        for (int i = 0; i < 3 * W; i++) step(1'b1, 8'($urandom));
        k = 0;
        while (!(m_reading && m_col == 4) && k < 20) begin
            step(1'b0, 8'h00);
            k++;
        end
        checks++;
        assert (k < 20) else begin
            failures++;
            $error("FAIL midrd_reach observed=%0d expected=<20", k);
        end
        chk("midrd_active", 72'(o_lb_rd_en), 72'(4'b0111));
        do_reset();
        observe(20, n_rd, fm, n_wv, fw, n_intr);
        chk("midrd_no_intr", 72'(n_intr), 72'(0));
        chk("midrd_no_rd",   72'(n_rd),   72'(0));
        fill_scenario("refill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences four line_buffer instances into a rotating 3-line window store for the Canny 3x3 stages (Gaussian, Sobel).
- Steers the incoming pixel stream into one buffer at a time, round-robin per line.
- Once three full lines are stored, drains them in lockstep and emits one 72-bit 3x3 window per read cycle.
- Pulses an interrupt each time a line is consumed, so the pixel source can refill.

Parameters:
- IMAGE_WIDTH, default definitions_pkg::IMAGE_WIDTH (512), pixels per line; must be a power of 2 and at least 4.
- NUM_LB, default 4, number of line buffers; fixed at 4, not user-overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_pixel_data  in  8  incoming pixel
- i_pixel_valid  in  1  pixel qualifier
- o_lb_wr_data  out  8  pixel fanned out to all buffers
- o_lb_wr_valid  out  4  one-hot write strobe; bit n writes buffer n
- o_lb_rd_en  out  4  per-buffer read-advance strobe
- i_lb_data  in  96  buffer n 24-bit tap output on bits [24n+23:24n]
- o_window  out  72  3x3 window {top row, mid row, bottom row}, 24 bits each
- o_window_valid  out  1  window qualifier
- o_intr  out  1  one-cycle pulse: one line consumed
- o_overflow  out  1  sticky: pixel arrived while all 4 lines full

Behaviour:
- Reset values: all outputs 0; wr_sel=0, rd_sel=0, all counters 0, state IDLE. Reset mid-operation aborts immediately and returns to these values; no pulse is emitted.
- Write path:
  - o_lb_wr_data = i_pixel_data (combinational).
  - o_lb_wr_valid = i_pixel_valid accepted ? (1<<wr_sel) : 0.
  - wr_pix_cnt increments per accepted pixel. On wrapping at IMAGE_WIDTH-1, wr_sel advances mod 4.
- Fill count fill_cnt (width clog2(4*IMAGE_WIDTH)+1):
  - +1 per accepted write, -1 per read cycle.
  - Write and read in the same cycle: unchanged.
- Full condition: fill_cnt == 4*IMAGE_WIDTH with i_pixel_valid high:
  - Pixel is dropped (no strobe, no counter change).
  - o_overflow set; it holds until rst.
- FSM:
  - IDLE -> RD when fill_cnt >= 3*IMAGE_WIDTH. Evaluated on the registered count, so RD starts the cycle after the 3*W-th accepted pixel.
  - In RD: o_lb_rd_en has bits rd_sel, rd_sel+1, rd_sel+2 (mod 4) set each cycle, for exactly IMAGE_WIDTH cycles, counted by rd_pix_cnt.
  - On the last read cycle: rd_sel advances mod 4, o_intr pulses on the next cycle, and state returns to IDLE.
  - IDLE re-enters RD when the threshold is met again. Minimum one IDLE cycle between lines.
- Window:
  - Each RD cycle registers o_window = {i_lb_data[rd_sel], i_lb_data[rd_sel+1], i_lb_data[rd_sel+2]}.
  - o_window_valid=1 on the following cycle (latency 1 from o_lb_rd_en).
  - Last two windows of a line contain wrapped columns (buffer pointer wrap); downstream masks border columns.
- Writes continue concurrently during RD into buffer wr_sel. Upstream guarantees wr_sel never equals an active read buffer by honouring o_intr flow control. The controller does not check this beyond fill_cnt.
- rd_pix_cnt and wr_pix_cnt wrap naturally (power-of-2 width); buffer read/write pointers stay aligned with them.

Decomposition:
- definitions_pkg:
  - IMAGE_WIDTH and NUM_LB constants.
  - typedef enum logic {IDLE, RD} lbc_state_t.
  - typedef logic [1:0] lb_sel_t.
  - typedef logic [23:0] lb_tap_t.
- No sub-module inside the controller.
- Top-level image_ctrl wrapper instantiates line_buffer_ctrl plus four line_buffer instances. The wrapper maps the active-high rst to the buffers' active-low rstN.

Test Plan (bench overrides IMAGE_WIDTH=8):
- Reset: assert rst mid-stream -> all outputs 0 asynchronously; after release, first pixel gives o_lb_wr_valid=4'b0001.
- Fill: write 24 pixels (values 0..23) back-to-back.
  - o_lb_wr_valid goes 0001 x8, 0010 x8, 0100 x8.
  - The cycle after pixel 23, o_lb_rd_en=4'b0111 for 8 cycles.
  - o_window_valid for 8 cycles; first o_window rows = {0,1,2},{8,9,10},{16,17,18}.
  - o_intr pulses once after the last read.
- Rotation: stream 4 more lines.
  - Read masks go 4'b1110, then 4'b1101, then 4'b1011 (rd_sel=3 wraps to buffers 3,0,1).
  - Exactly one o_intr per line.
- Concurrent write/read: write line 3 during the first RD -> fill_cnt returns to 24 at RD end; second RD starts with no extra pixels.
- Overflow: write 33 pixels with no reads completing -> pixel 33 dropped (o_lb_wr_valid=0); o_overflow=1 stays set until rst.
- Reset mid-RD: assert rst on read cycle 4 -> o_lb_rd_en=0 and o_intr never pulses; refill from zero reproduces the Fill scenario exactly.
